bf_sweep_checker: RTL and testbench

- Self-checking stimulus stage wrapped around the 3-input boolean function block `bf`, which has inputs a, b, c and output x.
- Drives {a,b,c} through all 8 combinations in order, holding each for a programmable number of cycles.
- Samples x at the end of each hold and compares it against an expected truth table.
- Reports per-combination failures, an error count and pass/done status.
- Replaces free-running toggle stimulus with a deterministic, clocked, self-checking sweep.

---
 rtl/bf_chk_pkg.sv | 13 +
 rtl/bf_hold_timer.sv | 29 ++
 rtl/bf_sweep_checker.sv | 97 +++++++++
 tb/tb_bf_sweep_checker.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bf_chk_pkg.sv
// Shared types and constants for the bf sweep checker.
package bf_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_COMBOS = 8;
    localparam int IDX_W      = 3;

endpackage

// File: rtl/bf_hold_timer.sv
// Hold counter: counts 0..HOLD_CYCLES-1 while enabled, flags the last cycle.
module bf_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

    logic [7:0] r_cnt;

    // With HOLD_CYCLES=1 the count never leaves 0 and every enabled edge is terminal.
    assign o_tc = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/bf_sweep_checker.sv
// Clocked sweep of {a,b,c} over all 8 combinations, checking x against EXPECT
// at the end of each hold window and accumulating per-combination failures.
module bf_sweep_checker
    import bf_chk_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] EXPECT      = 8'hEA
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_x,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_cnt,
    output logic [7:0] o_fail_vec
);

    state_t             r_state, w_state_nx;
    logic [IDX_W-1:0]   r_idx, w_idx_nx;
    logic [2:0]         r_abc;
    logic [3:0]         r_err, w_err_nx;
    logic [7:0]         r_fail, w_fail_nx;
    logic               w_clr, w_en, w_tc, w_mis, w_last;

    bf_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_tc    (w_tc)
    );

    assign w_mis  = (i_x != EXPECT[r_idx]);
    assign w_last = (r_idx == IDX_W'(NUM_COMBOS - 1));

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_err_nx   = r_err;
        w_fail_nx  = r_fail;
        w_clr      = 1'b0;
        w_en       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_state_nx = DRIVE;
                    w_idx_nx   = '0;
                    w_err_nx   = '0;
                    w_fail_nx  = '0;
                    w_clr      = 1'b1;
                end
            end
            DRIVE: begin
                w_en = 1'b1;
                if (w_tc) begin
                    if (w_mis) begin
                        w_fail_nx[r_idx] = 1'b1;
                        w_err_nx         = r_err + 4'd1;
                    end
                    if (w_last) w_state_nx = DONE;
                    else        w_idx_nx   = r_idx + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_abc   <= '0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_err   <= w_err_nx;
            r_fail  <= w_fail_nx;
            // Stimulus follows idx on the same edge; forced to 0 outside a sweep.
            r_abc   <= (w_state_nx == DRIVE) ? w_idx_nx : 3'b000;
        end
    end

    assign {o_a, o_b, o_c} = r_abc;
    assign o_busy          = (r_state == DRIVE);
    assign o_done          = (r_state == DONE);
    assign o_pass          = o_done && (r_err == 4'd0);
    assign o_err_cnt       = r_err;
    assign o_fail_vec      = r_fail;

endmodule

// File: tb/tb_bf_sweep_checker.sv
// Bench: two checkers (hold 4 and hold 1) driving a modelled bf block with injectable faults.
module tb_bf_sweep_checker;

    localparam logic [7:0] EXP_TT = 8'hEA;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic       start4 = 0, start1 = 0;
    logic [7:0] flip4 = 0, flip1 = 0;
    logic       a4, b4, c4, busy4, done4, pass4;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [3:0] err4, err1;
    logic [7:0] fv4, fv1;
    logic       x4, x1;

    int checks = 0;
    int failures = 0;

    function automatic logic bf_ref(input logic [2:0] i);
        return (i[2] & i[1]) | i[0];
    endfunction

    assign x4 = bf_ref({a4, b4, c4}) ^ flip4[{a4, b4, c4}];
    assign x1 = bf_ref({a1, b1, c1}) ^ flip1[{a1, b1, c1}];

    bf_sweep_checker #(.HOLD_CYCLES(4), .EXPECT(8'hEA)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_x(x4),
        .o_a(a4), .o_b(b4), .o_c(c4), .o_busy(busy4), .o_done(done4),
        .o_pass(pass4), .o_err_cnt(err4), .o_fail_vec(fv4)
    );

    bf_sweep_checker #(.HOLD_CYCLES(1), .EXPECT(8'hEA)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_x(x1),
        .o_a(a1), .o_b(b1), .o_c(c1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_err_cnt(err1), .o_fail_vec(fv1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mismatch set from the truth-table rule: x seen for combo i vs EXPECT bit i.
    task automatic model(input logic [7:0] flip, output logic [7:0] fv, output logic [3:0] ec);
        fv = 0;
        ec = 0;
        for (int i = 0; i < 8; i++) begin
            logic xv;
            xv = bf_ref(3'(i)) ^ flip[i];
            if (xv != EXP_TT[i]) begin
                fv[i] = 1'b1;
                ec++;
            end
        end
    endtask

    // Hold-4 sweep; optional start re-pulse or reset at cycle t after acceptance.
    task automatic sweep4(input logic [7:0] flip, input logic [3:0] e_err, input logic [7:0] e_fv,
                          input int repulse_at, input int rst_at);
        logic seq_ok;
        flip4  = flip;
        start4 = 1;
        step();
        start4 = 0;
        chk("accept_clear", {done4, busy4, err4, fv4}, {1'b0, 1'b1, 4'd0, 8'd0});
        seq_ok = 1;
        for (int t = 0; t < 32; t++) begin
            if (t == rst_at) begin
                rst_n = 0;
                step();
                rst_n = 1;
                chk("mid_rst_state", {a4, b4, c4, busy4, done4, err4, fv4}, 18'd0);
                for (int w = 0; w < 40; w++) begin
                    if (done4 || busy4) seq_ok = 0;
                    step();
                end
                chk("mid_rst_no_done", {31'd0, seq_ok}, 32'd1);
                return;
            end
            if ({a4, b4, c4} !== 3'(t / 4) || busy4 !== 1'b1 || done4 !== 1'b0) begin
                if (seq_ok)
                    $display("FAIL seq4 t=%0d actual abc=%0d busy=%0b done=%0b required abc=%0d busy=1 done=0",
                             t, {a4, b4, c4}, busy4, done4, t / 4);
                seq_ok = 0;
            end
            start4 = (t == repulse_at);
            step();
            start4 = 0;
        end
        checks++;
        if (!seq_ok) failures++;
        chk("end_status", {a4, b4, c4, busy4, done4, pass4}, {3'd0, 1'b0, 1'b1, e_err == 0});
        chk("end_err", err4, e_err);
        chk("end_fvec", fv4, e_fv);
    endtask

    typedef struct {
        logic [7:0] flip;
        logic [3:0] err;
        logic [7:0] fv;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] mfv;
        logic [3:0] mec;
        logic [7:0] rf;
        logic       ok1;

        tbl[0] = '{8'h00, 4'd0, 8'h00};
        tbl[1] = '{8'hEA, 4'd5, 8'hEA};   // x stuck at 0
        tbl[2] = '{8'h00, 4'd0, 8'h00};   // restart from DONE with a good bf
        tbl[3] = '{8'hFF, 4'd8, 8'hFF};
        tbl[4] = '{8'h81, 4'd2, 8'h81};
        tbl[5] = '{8'h15, 4'd3, 8'h15};   // x stuck at 1 pattern

        rst_n = 0;
        repeat (3) step();
        chk("rst_dut4", {a4, b4, c4, busy4, done4, pass4, err4, fv4}, 18'd0);
        chk("rst_dut1", {a1, b1, c1, busy1, done1, pass1, err1, fv1}, 18'd0);
        rst_n = 1;
        step();

        for (int i = 0; i < 6; i++)
            sweep4(tbl[i].flip, tbl[i].err, tbl[i].fv, -1, -1);

        sweep4(8'h00, 4'd0, 8'h00, 10, -1);   // start mid-sweep is ignored
        sweep4(8'h00, 4'd0, 8'h00, -1, 13);   // reset while idx=3

        for (int r = 0; r < 6; r++) begin
            rf = 8'($urandom);
            model(rf, mfv, mec);
            sweep4(rf, mec, mfv, -1, -1);
        end

        foreach (tbl[i]) begin
            if (i > 1) break;
            flip1  = tbl[i].flip;
            start1 = 1;
            step();
            start1 = 0;
            ok1 = 1;
            for (int t = 0; t < 8; t++) begin
                if ({a1, b1, c1} !== 3'(t) || busy1 !== 1'b1) ok1 = 0;
                step();
            end
            chk("h1_seq", {31'd0, ok1}, 32'd1);
            chk("h1_end", {done1, pass1, err1, fv1}, {1'b1, tbl[i].err == 0, tbl[i].err, tbl[i].fv});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
